// File: rtl/fib_random_encoder_p.sv
// fib_random_encoder_p: serial MSB-first binary to Fibonacci-base encoder.
// Weights w(0)=1, w(1)=2, w(i)=w(i-1)+w(i-2) are stepped down on the fly from constants.
// mode=0 yields the canonical Zeckendorf code. mode=1 lets an LFSR choose optional digits,
// which gives a non-unique but exactly decodable code.
// Optional macro FIBENC_SEED_PORT_EN adds seed_load/seed_val for run-time LFSR seeding.

module fib_random_encoder_p #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 128,
  parameter int unsigned FIB_W = 96,
  parameter logic [31:0] SEED  = 32'hACE1_2024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_encode,
  input  logic             mode,
  input  logic [IN_W-1:0]  input_binary,
`ifdef FIBENC_SEED_PORT_EN
  input  logic             seed_load,
  input  logic [31:0]      seed_val,
`endif
  output logic [OUT_W-1:0] fibonacci_random,
  output logic             convert_done,
  output logic             busy,
  output logic             range_err
);

  localparam int unsigned FW1   = FIB_W + 1;
  localparam int unsigned IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned CMP_W = (IN_W > FIB_W) ? IN_W : FIB_W;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;

  function automatic logic [FIB_W-1:0] fib_weight(int unsigned n);
    logic [FIB_W-1:0] a, b, t;
    a = FIB_W'(1);
    b = FIB_W'(2);
    if (n == 0) return a;
    for (int unsigned i = 1; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // True when every weight up to w(n) fits in FIB_W bits.
  function automatic bit fib_fits(int unsigned n);
    logic [FIB_W:0] a, b, t;
    bit ok;
    a  = FW1'(1);
    b  = FW1'(2);
    ok = 1'b1;
    for (int unsigned i = 1; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
      if (t[FIB_W]) ok = 1'b0;
    end
    return ok;
  endfunction

  if (!fib_fits(OUT_W + 1)) begin : g_bad_fib_w
    $error("fib_random_encoder_p: FIB_W too narrow to hold w(OUT_W+1)");
  end

  localparam logic [FIB_W-1:0] W_TOP  = fib_weight(OUT_W);
  localparam logic [FIB_W-1:0] W_NEXT = fib_weight(OUT_W - 1);
  localparam logic [FIB_W-1:0] MAXV   = fib_weight(OUT_W + 1) - FIB_W'(2);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e             state_q, state_d;
  logic [FIB_W-1:0]   rem_q, rem_d, wh_q, wh_d, wl_q, wl_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mode_q, mode_d;
  logic [OUT_W-1:0]   code_q, code_d, fr_q, fr_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic               done_q, done_d, busy_q, busy_d, rerr_q, rerr_d;
  logic               in_too_big, forced, digit;

  assign in_too_big = CMP_W'(input_binary) > CMP_W'(MAXV);

  // Next-state, digit decision and output updates.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wh_d    = wh_q;
    wl_d    = wl_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    code_d  = code_q;
    lfsr_d  = lfsr_q;
    fr_d    = fr_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    rerr_d  = rerr_q;
    // Lower digits sum to wh-2, so anything at or above wh-1 must take this digit.
    forced  = rem_q >= (wh_q - FIB_W'(1));
    digit   = 1'b0;
    if (forced) digit = 1'b1;
    else if (rem_q >= wl_q) digit = mode_q ? lfsr_q[0] : 1'b1;

    case (state_q)
      StIdle: begin
`ifdef FIBENC_SEED_PORT_EN
        if (seed_load) lfsr_d = (seed_val == 32'h0) ? 32'h1 : seed_val;
`endif
        if (en_encode) begin
          rem_d   = FIB_W'(input_binary);
          mode_d  = mode;
          wh_d    = W_TOP;
          wl_d    = W_NEXT;
          idx_d   = IDX_W'(OUT_W - 1);
          code_d  = '0;
          busy_d  = 1'b1;
          rerr_d  = 1'b0;
          state_d = in_too_big ? StDone : StConv;
        end
      end
      StConv: begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
        code_d = {code_q[OUT_W-2:0], digit};
        if (digit) rem_d = rem_q - wl_q;
        wh_d  = wl_q;
        wl_d  = wh_q - wl_q;
        idx_d = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          fr_d    = {code_q[OUT_W-2:0], digit};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rerr_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StDone: begin
        fr_d    = '0;
        rerr_d  = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      code_q  <= '0;
      lfsr_q  <= SEED_EFF;
      fr_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      code_q  <= code_d;
      lfsr_q  <= lfsr_d;
      fr_q    <= fr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rerr_q  <= rerr_d;
    end
  end

  // The last digit must absorb the whole remainder.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StConv && idx_q == '0) begin
      assert (rem_d == '0) else $error("fib_random_encoder_p: non-zero remainder at digit 0");
    end
  end

  assign fibonacci_random = fr_q;
  assign convert_done     = done_q;
  assign busy             = busy_q;
  assign range_err        = rerr_q;

endmodule

// File: tb/tb_fib_random_encoder_p.sv
// Directed self-checking bench for fib_random_encoder_p (default and OUT_W=8 instances).
module tb_fib_random_encoder_p;

  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         en_b = 1'b0, mode_b = 1'b0;
  logic [63:0]  in_b = '0;
  logic [127:0] fr_b;
  logic         done_b, busy_b, re_b;
  logic         en_s = 1'b0, mode_s = 1'b0;
  logic [7:0]   in_s = '0;
  logic [7:0]   fr_s;
  logic         done_s, busy_s, re_s;
`ifdef FIBENC_SEED_PORT_EN
  logic         seed_load_b = 1'b0;
  logic [31:0]  seed_val_b = '0;
  logic         seed_load_s = 1'b0;
  logic [31:0]  seed_val_s = '0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] wt [0:129];
  logic [127:0] lowsum [0:129];
  logic [31:0]  lf_b, lf_s;

  fib_random_encoder_p u_big (
    .clk              (clk),
    .rst              (rst),
    .en_encode        (en_b),
    .mode             (mode_b),
    .input_binary     (in_b),
`ifdef FIBENC_SEED_PORT_EN
    .seed_load        (seed_load_b),
    .seed_val         (seed_val_b),
`endif
    .fibonacci_random (fr_b),
    .convert_done     (done_b),
    .busy             (busy_b),
    .range_err        (re_b)
  );

  fib_random_encoder_p #(.IN_W(8), .OUT_W(8), .FIB_W(16)) u_small (
    .clk              (clk),
    .rst              (rst),
    .en_encode        (en_s),
    .mode             (mode_s),
    .input_binary     (in_s),
`ifdef FIBENC_SEED_PORT_EN
    .seed_load        (seed_load_s),
    .seed_val         (seed_val_s),
`endif
    .fibonacci_random (fr_s),
    .convert_done     (done_s),
    .busy             (busy_s),
    .range_err        (re_s)
  );

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Reference: a digit is mandatory when rem exceeds the sum of all lower weights;
  // otherwise optional digits are taken greedily (mode 0) or when the LFSR says so.
  task automatic model_code(input logic [63:0] v, input logic m, input int n,
                            input logic [31:0] lf_in, output logic [127:0] code,
                            output logic [31:0] lf_out);
    logic [127:0] rem;
    logic [31:0] lf;
    rem = {64'h0, v};
    code = '0;
    lf = lf_in;
    for (int i = n - 1; i >= 0; i--) begin
      if (rem > lowsum[i] || (rem >= wt[i] && (m == 1'b0 || lf[0]))) begin
        code[i] = 1'b1;
        rem = rem - wt[i];
      end
      lf = lfsr_step(lf);
    end
    lf_out = lf;
  endtask

  function automatic logic [127:0] wsum(input logic [127:0] c, input int n);
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < n; i++) if (c[i]) s = s + wt[i];
    return s;
  endfunction

  task automatic wait_big(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (done_b !== 1'b1 && lat < 300) begin
      if (busy_b !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy_b !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic run_big(input logic m, input logic [63:0] v, output logic [127:0] code,
                         output logic rerr, output int lat, output bit busy_ok);
    en_b = 1'b1; mode_b = m; in_b = v;
    @(posedge clk); #1;
    en_b = 1'b0; mode_b = ~m; in_b = ~v;
    wait_big(lat, busy_ok);
    code = fr_b;
    rerr = re_b;
  endtask

  task automatic run_small(input logic m, input logic [7:0] v, output logic [7:0] code,
                           output logic rerr, output int lat);
    en_s = 1'b1; mode_s = m; in_s = v;
    @(posedge clk); #1;
    en_s = 1'b0; mode_s = ~m; in_s = ~v;
    lat = 0;
    while (done_s !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    code = fr_s;
    rerr = re_s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 5;
    if (fr_b !== '0) begin n_bad++; $display("FAIL reset_code got %h want 0", fr_b); end
    if (done_b !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done_b); end
    if (busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_b); end
    if (re_b !== 1'b0) begin n_bad++; $display("FAIL reset_rerr got %b want 0", re_b); end
    if (fr_s !== '0) begin n_bad++; $display("FAIL reset_small got %h want 0", fr_s); end
    rst = 1'b0;
    lf_b = SEED;
    lf_s = SEED;
  endtask

  task automatic test_greedy();
    logic [63:0]  vin  [7] = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd12, 64'd100};
    logic [127:0] vexp [7] = '{128'h0, 128'h1, 128'h2, 128'h4, 128'h5, 128'h15, 128'h214};
    logic [127:0] code, exp, d;
    logic rerr;
    int lat;
    bit bok;
    for (int i = 0; i < 7; i++) begin
      run_big(1'b0, vin[i], code, rerr, lat, bok);
      model_code(vin[i], 1'b0, 128, lf_b, d, lf_b);
      n_cmp += 4;
      if (code !== vexp[i]) begin n_bad++; $display("FAIL greedy_code[%0d] got %h want %h", vin[i], code, vexp[i]); end
      if (rerr !== 1'b0) begin n_bad++; $display("FAIL greedy_rerr[%0d] got %b want 0", vin[i], rerr); end
      if (lat != 128) begin n_bad++; $display("FAIL greedy_latency[%0d] got %0d want 128", vin[i], lat); end
      if (!bok) begin n_bad++; $display("FAIL greedy_busy[%0d] busy not high through conversion", vin[i]); end
      @(posedge clk); #1;
      n_cmp++;
      if (done_b !== 1'b0) begin n_bad++; $display("FAIL done_pulse[%0d] got %b want 0", vin[i], done_b); end
    end
    run_big(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, code, rerr, lat, bok);
    model_code(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 128, lf_b, exp, lf_b);
    n_cmp += 2;
    if (code !== exp) begin n_bad++; $display("FAIL greedy_max64 got %h want %h", code, exp); end
    if ((code & (code >> 1)) !== '0) begin n_bad++; $display("FAIL greedy_adjacent got %h want no adjacent ones", code); end
  endtask

  task automatic test_random();
    logic [127:0] code, exp, g, d;
    logic [63:0] v;
    logic [31:0] dl;
    logic rerr;
    int lat, differ, bad_code, bad_sum, bad_lat;
    bit bok;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    lf_b = SEED; lf_s = SEED;
    differ = 0; bad_code = 0; bad_sum = 0; bad_lat = 0;
    for (int i = 0; i < 40; i++) begin
      v = {$urandom, $urandom};
      run_big(1'b1, v, code, rerr, lat, bok);
      model_code(v, 1'b1, 128, lf_b, exp, lf_b);
      model_code(v, 1'b0, 128, 32'h1, g, dl);
      n_cmp += 3;
      if (code !== exp) begin n_bad++; $display("FAIL random_code[%h] got %h want %h", v, code, exp); end
      if (wsum(code, 128) !== {64'h0, v}) begin n_bad++; $display("FAIL random_sum[%h] got %h want %h", v, wsum(code, 128), v); end
      if (lat != 128) begin n_bad++; $display("FAIL random_latency got %0d want 128", lat); end
      if (code !== g) differ++;
    end
    n_cmp++;
    if (differ == 0) begin n_bad++; $display("FAIL random_differs got %0d differing want >0", differ); end
    d = '0;
  endtask

  task automatic test_small();
    logic [7:0] code;
    logic [127:0] exp;
    logic rerr;
    int lat;
    run_small(1'b0, 8'd87, code, rerr, lat);
    model_code(64'd87, 1'b0, 8, lf_s, exp, lf_s);
    n_cmp += 3;
    if (code !== 8'hFF) begin n_bad++; $display("FAIL small_maxv got %h want ff", code); end
    if (rerr !== 1'b0) begin n_bad++; $display("FAIL small_maxv_rerr got %b want 0", rerr); end
    if (lat != 8) begin n_bad++; $display("FAIL small_latency got %0d want 8", lat); end
    run_small(1'b0, 8'd88, code, rerr, lat);
    n_cmp += 3;
    if (code !== 8'h00) begin n_bad++; $display("FAIL small_over_code got %h want 00", code); end
    if (rerr !== 1'b1) begin n_bad++; $display("FAIL small_over_rerr got %b want 1", rerr); end
    if (lat != 1) begin n_bad++; $display("FAIL small_over_latency got %0d want 1", lat); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 3;
    if (re_s !== 1'b1) begin n_bad++; $display("FAIL small_rerr_hold got %b want 1", re_s); end
    if (done_s !== 1'b0) begin n_bad++; $display("FAIL small_done_hold got %b want 0", done_s); end
    if (busy_s !== 1'b0) begin n_bad++; $display("FAIL small_busy_hold got %b want 0", busy_s); end
    run_small(1'b0, 8'd5, code, rerr, lat);
    model_code(64'd5, 1'b0, 8, lf_s, exp, lf_s);
    n_cmp += 2;
    if (code !== 8'h08) begin n_bad++; $display("FAIL small_five got %h want 08", code); end
    if (rerr !== 1'b0) begin n_bad++; $display("FAIL small_rerr_clear got %b want 0", rerr); end
    run_small(1'b0, 8'd255, code, rerr, lat);
    n_cmp += 2;
    if (rerr !== 1'b1) begin n_bad++; $display("FAIL small_255_rerr got %b want 1", rerr); end
    if (lat != 1) begin n_bad++; $display("FAIL small_255_latency got %0d want 1", lat); end
    run_small(1'b1, 8'd60, code, rerr, lat);
    model_code(64'd60, 1'b1, 8, lf_s, exp, lf_s);
    n_cmp += 2;
    if (code !== exp[7:0]) begin n_bad++; $display("FAIL small_random got %h want %h", code, exp[7:0]); end
    if (wsum({120'h0, code}, 8) !== 128'd60) begin n_bad++; $display("FAIL small_random_sum got %0d want 60", wsum({120'h0, code}, 8)); end
  endtask

  task automatic test_ignore();
    logic [127:0] code, d;
    int dones, first;
    en_b = 1'b1; mode_b = 1'b0; in_b = 64'd100;
    @(posedge clk); #1;
    en_b = 1'b0;
    dones = 0; first = 0; code = '0;
    for (int c = 1; c <= 140; c++) begin
      if (c == 5) begin en_b = 1'b1; in_b = 64'd7; mode_b = 1'b1; end
      else en_b = 1'b0;
      @(posedge clk); #1;
      if (done_b === 1'b1) begin
        dones++;
        if (first == 0) begin first = c; code = fr_b; end
      end
    end
    model_code(64'd100, 1'b0, 128, lf_b, d, lf_b);
    n_cmp += 3;
    if (dones != 1) begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", dones); end
    if (first != 128) begin n_bad++; $display("FAIL ignore_latency got %0d want 128", first); end
    if (code !== 128'h214) begin n_bad++; $display("FAIL ignore_code got %h want 214", code); end
  endtask

  task automatic test_rst_abort();
    logic [127:0] code, exp;
    logic rerr;
    int lat, dones;
    bit bok;
    en_b = 1'b1; mode_b = 1'b0; in_b = 64'd100;
    @(posedge clk); #1;
    en_b = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp += 4;
    if (busy_b !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy_b); end
    if (done_b !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b want 0", done_b); end
    if (fr_b !== '0) begin n_bad++; $display("FAIL abort_code got %h want 0", fr_b); end
    if (re_b !== 1'b0) begin n_bad++; $display("FAIL abort_rerr got %b want 0", re_b); end
    dones = 0;
    for (int c = 0; c < 140; c++) begin
      @(posedge clk); #1;
      if (done_b === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", dones); end
    lf_b = SEED; lf_s = SEED;
    run_big(1'b1, 64'h0123_4567_89AB_CDEF, code, rerr, lat, bok);
    model_code(64'h0123_4567_89AB_CDEF, 1'b1, 128, lf_b, exp, lf_b);
    n_cmp++;
    if (code !== exp) begin n_bad++; $display("FAIL abort_reseed got %h want %h", code, exp); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d;
    int lat;
    bit bok;
    en_b = 1'b1; mode_b = 1'b0; in_b = 64'd12;
    @(posedge clk); #1;
    wait_big(lat, bok);
    n_cmp += 2;
    if (lat != 128) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 128", lat); end
    if (fr_b !== 128'h15) begin n_bad++; $display("FAIL b2b_first_code got %h want 15", fr_b); end
    @(posedge clk); #1;
    en_b = 1'b0;
    n_cmp += 2;
    if (busy_b !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_busy got %b want 1", busy_b); end
    if (done_b !== 1'b0) begin n_bad++; $display("FAIL b2b_restart_done got %b want 0", done_b); end
    wait_big(lat, bok);
    n_cmp += 2;
    if (lat != 128) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 128", lat); end
    if (fr_b !== 128'h15) begin n_bad++; $display("FAIL b2b_second_code got %h want 15", fr_b); end
    model_code(64'd12, 1'b0, 128, lf_b, d, lf_b);
    model_code(64'd12, 1'b0, 128, lf_b, d, lf_b);
  endtask

`ifdef FIBENC_SEED_PORT_EN
  task automatic run_seed(input logic [31:0] s, input logic [63:0] v, input bit mid,
                          output logic [127:0] code, output int lat);
    bit bok;
    seed_load_b = 1'b1; seed_val_b = s; en_b = 1'b1; mode_b = 1'b1; in_b = v;
    @(posedge clk); #1;
    seed_load_b = 1'b0; en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    seed_load_b = mid; seed_val_b = 32'h5555_AAAA;
    @(posedge clk); #1;
    seed_load_b = 1'b0;
    wait_big(lat, bok);
    lat = lat + 4;
    code = fr_b;
  endtask

  task automatic test_seed();
    logic [127:0] ca, cb, cc, cd, exp;
    logic [31:0] dl;
    int lat;
    run_seed(32'h1234_5678, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, ca, lat);
    model_code(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 128, 32'h1234_5678, exp, dl);
    n_cmp += 2;
    if (ca !== exp) begin n_bad++; $display("FAIL seed_a got %h want %h", ca, exp); end
    if (lat != 128) begin n_bad++; $display("FAIL seed_latency got %0d want 128", lat); end
    run_seed(32'h1234_5678, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, cb, lat);
    n_cmp++;
    if (cb !== ca) begin n_bad++; $display("FAIL seed_repeat got %h want %h", cb, ca); end
    run_seed(32'h9ABC_DEF0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, cc, lat);
    model_code(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 128, 32'h9ABC_DEF0, exp, dl);
    n_cmp += 2;
    if (cc !== exp) begin n_bad++; $display("FAIL seed_c got %h want %h", cc, exp); end
    if (cc === ca) begin n_bad++; $display("FAIL seed_differ got %h want differing from %h", cc, ca); end
    run_seed(32'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, cd, lat);
    model_code(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 128, 32'h1, exp, dl);
    n_cmp++;
    if (cd !== exp) begin n_bad++; $display("FAIL seed_zero got %h want %h", cd, exp); end
  endtask
`endif

  initial begin
    wt[0] = 128'd1;
    wt[1] = 128'd2;
    for (int i = 2; i < 130; i++) wt[i] = wt[i-1] + wt[i-2];
    lowsum[0] = '0;
    for (int i = 1; i < 130; i++) lowsum[i] = lowsum[i-1] + wt[i-1];
    test_reset();
    test_greedy();
    test_random();
    test_small();
    test_ignore();
    test_rst_abort();
    test_back_to_back();
`ifdef FIBENC_SEED_PORT_EN
    test_seed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
